// File: rtl/aes_stream_loader.sv
// aes_stream_loader
//
// Byte-stream front end for aes_core. Sixteen key bytes, then sixteen
// plaintext bytes, are accepted over a valid/ready interface. Both values are
// presented on stable 128-bit buses. The block then pulses load for one
// cycle and waits for the core's done. It captures the cyphertext and returns
// it as sixteen bytes over a second valid/ready interface. The first byte on
// either stream maps to bits [127:120].
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset_n    synchronous active-low reset
//   in_data    input byte
//   in_valid   in_data valid
//   in_ready   loader accepts a byte this cycle (COLLECT only)
//   out_data   cyphertext byte
//   out_valid  out_data valid (SEND only)
//   out_ready  sink accepts a byte this cycle
//   key        128-bit key to aes_core
//   plaintext  128-bit plaintext to aes_core
//   load       one-cycle start pulse to aes_core
//   core_done  done from aes_core
//   cyphertext result from aes_core
//   busy       high while in LOAD or WAIT
//   err        sticky flag: core_done never arrived within TIMEOUT_CYCLES
module aes_stream_loader #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] key,
    output logic [127:0] plaintext,
    output logic         load,
    input  logic         core_done,
    input  logic [127:0] cyphertext,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LOAD    = 2'd1,
        WAIT    = 2'd2,
        SEND    = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state_reg, state_next;
    logic [4:0]      cnt_reg, cnt_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic [127:0]    key_reg, key_next;
    logic [127:0]    pt_reg, pt_next;
    logic [127:0]    shift_reg, shift_next;
    logic            err_reg, err_next;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg  <= COLLECT;
            cnt_reg    <= '0;
            to_cnt_reg <= '0;
            key_reg    <= '0;
            pt_reg     <= '0;
            shift_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            to_cnt_reg <= to_cnt_next;
            key_reg    <= key_next;
            pt_reg     <= pt_next;
            shift_reg  <= shift_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        to_cnt_next = to_cnt_reg;
        key_next    = key_reg;
        pt_next     = pt_reg;
        shift_next  = shift_reg;
        err_next    = err_reg;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        load        = 1'b0;
        busy        = 1'b0;

        case (state_reg)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Bytes 0-15 fill the key and bytes 16-31 fill the
                    // plaintext. Shifting left puts the first byte in the
                    // top lane.
                    if (!cnt_reg[4]) begin
                        key_next = {key_reg[119:0], in_data};
                    end else begin
                        pt_next = {pt_reg[119:0], in_data};
                    end
                    if (cnt_reg == 5'd31) begin
                        state_next = LOAD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 5'd1;
                    end
                end
            end

            LOAD: begin
                // core_done is deliberately not looked at here. It may still
                // hold the previous result until the core sees this load.
                load        = 1'b1;
                busy        = 1'b1;
                to_cnt_next = '0;
                state_next  = WAIT;
            end

            WAIT: begin
                busy = 1'b1;
                if (core_done) begin
                    shift_next = cyphertext;
                    cnt_next   = '0;
                    state_next = SEND;
                end else if (to_cnt_reg == TO_LAST) begin
                    err_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = COLLECT;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end

            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    shift_next = {shift_reg[119:0], 8'h00};
                    if (cnt_reg == 5'd15) begin
                        cnt_next   = '0;
                        state_next = COLLECT;
                    end else begin
                        cnt_next = cnt_reg + 5'd1;
                    end
                end
            end

            default: state_next = COLLECT;
        endcase
    end

    // The top byte of the shift register is the byte currently offered. It
    // stays put until a transfer shifts the next byte up.
    assign out_data  = shift_reg[127:120];
    assign key       = key_reg;
    assign plaintext = pt_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_aes_stream_loader.sv
// Bench for aes_stream_loader. A stub aes_core computes real AES-128 with a
// behavioural model and has a configurable done latency or a hang mode.
// Expected output bytes go into a scoreboard queue when a block is issued.
// A negedge monitor pops the queue and checks each output transfer.
module tb_aes_stream_loader;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         load;
    logic         core_done = 1'b0;
    logic [127:0] cyphertext = '0;
    logic         busy;
    logic         err;

    aes_stream_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .key        (key),
        .plaintext  (plaintext),
        .load       (load),
        .core_done  (core_done),
        .cyphertext (cyphertext),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    int           tests = 0;
    int           fails = 0;
    logic [7:0]   exp_q[$];
    int           in_cnt = 0;
    int           out_blk = 0;
    logic         prev_stall = 1'b0;
    logic [7:0]   prev_data = 8'h00;
    int           out_mode = 0;
    logic         out_force = 1'b1;
    logic         stub_hang = 1'b0;
    int           stub_lat = 45;
    logic         stub_busy = 1'b0;
    int           stub_cnt = 0;
    logic [127:0] lat_key = '0;
    logic [127:0] lat_pt = '0;
    logic [7:0]   sbox_t[256];

    // ---------------- check helpers ----------------
    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- AES-128 reference model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] x;
        logic [7:0] y;
        for (int i = 0; i < 256; i++) begin
            x   = 8'(i);
            inv = 8'h00;
            for (int j = 1; j < 256; j++) begin
                y = 8'(j);
                if (gmul(x, y) == 8'h01) inv = y;
            end
            sbox_t[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w[44];
        logic [7:0]   st[16];
        logic [7:0]   tmp[16];
        logic [7:0]   rc;
        logic [31:0]  t;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
                    ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        // State byte i is row i%4, column i/4.
        for (int i = 0; i < 16; i++) st[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) tmp[i] = sbox_t[st[i]];
            for (int i = 0; i < 16; i++) st[i] = tmp[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                    st[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    // ---------------- stub aes_core ----------------
    always @(posedge clk) begin
        if (!reset_n) begin
            core_done <= 1'b0;
            stub_busy <= 1'b0;
        end else if (load) begin
            core_done <= 1'b0;
            stub_busy <= 1'b1;
            stub_cnt  <= 1;
            lat_key   <= key;
            lat_pt    <= plaintext;
        end else if (stub_busy) begin
            if (!stub_hang && stub_cnt == stub_lat) begin
                core_done  <= 1'b1;
                cyphertext <= aes_enc(lat_key, lat_pt);
                stub_busy  <= 1'b0;
            end
            stub_cnt <= stub_cnt + 1;
        end
    end

    // ---------------- output ready driver ----------------
    always @(posedge clk) begin
        #2;
        if (out_mode == 1) out_ready = ($urandom_range(1) == 1);
        else               out_ready = out_force;
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [7:0] e;
        if (!reset_n) begin
            exp_q.delete();
            in_cnt     = 0;
            out_blk    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check1("out_hold_valid", out_valid, 1'b1);
                check8("out_hold_data", out_data, prev_data);
            end
            if (out_valid) check1("no_overlap_in_ready", in_ready, 1'b0);
            if (busy && !load) begin
                check128("key_stable_wait", key, lat_key);
                check128("pt_stable_wait", plaintext, lat_pt);
            end
            if (in_valid && in_ready) in_cnt++;
            if (load) begin
                checki("load_after_32_transfers", in_cnt, 32);
                in_cnt = 0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL out_unexpected: got %h expected no transfer", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check8("out_byte", out_data, e);
                    $display("[TB] out byte %0d = %h", out_blk, out_data);
                end
                out_blk++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send_byte(input logic [7:0] b, input int p_idle);
        int n;
        while (p_idle > 0 && $urandom_range(99) < p_idle) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles expected 1", n);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_block(input logic [127:0] k, input logic [127:0] p,
                              input logic [127:0] exp, input bit push, input int p_idle);
        for (int i = 0; i < 32; i++) begin
            if (i < 16) send_byte(k[127-8*i -: 8], p_idle);
            else        send_byte(p[127-8*(i-16) -: 8], p_idle);
        end
        in_valid = 1'b0;
        check1("load_pulse", load, 1'b1);
        check128("key_bus", key, k);
        check128("plaintext_bus", plaintext, p);
        $display("[TB] block key=%h pt=%h loaded", k, p);
        if (push) begin
            for (int i = 0; i < 16; i++) exp_q.push_back(exp[127-8*i -: 8]);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || out_valid || exp_q.size() != 0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_q.size());
        end
        checki("scoreboard_empty", exp_q.size(), 0);
        check1("idle_in_ready", in_ready, 1'b1);
    endtask

    task automatic check_reset_values();
        check128("rst_key", key, '0);
        check128("rst_plaintext", plaintext, '0);
        check1("rst_load", load, 1'b0);
        check1("rst_out_valid", out_valid, 1'b0);
        check8("rst_out_data", out_data, 8'h00);
        check1("rst_busy", busy, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_in_ready", in_ready, 1'b1);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check_reset_values();
        $display("[TB] reset pulse applied");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] rk;
        logic [127:0] rp;
        int n;
        int base;

        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_reset_values();

        // FIPS-197 C.1, no backpressure.
        send_block(C1_KEY, C1_PT, C1_CT, 1'b1, 0);
        drain();
        check1("c1_err", err, 1'b0);

        // Random input gaps.
        send_block(C1_KEY, C1_PT, C1_CT, 1'b1, 50);
        drain();

        // Output stalls on byte 0 and byte 15.
        out_force = 1'b0;
        send_block(C1_KEY, C1_PT, C1_CT, 1'b1, 0);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check1("stall_out_valid", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check8("stall_byte0", out_data, 8'h69);
            @(posedge clk); #1;
        end
        out_force = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
        end
        out_force = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check8("stall_byte15", out_data, 8'h5a);
            check1("stall_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_force = 1'b1;
        @(posedge clk); #1;
        check1("after_last_out_valid", out_valid, 1'b0);
        check1("after_last_in_ready", in_ready, 1'b1);
        drain();

        // Back-to-back blocks with no idle cycles.
        stub_lat = 45;
        send_block(C1_KEY, C1_PT, C1_CT, 1'b1, 0);
        send_block('0, '0, Z_CT, 1'b1, 0);
        drain();

        // Random data, random backpressure, random core latency.
        out_mode = 1;
        for (int b = 0; b < 4; b++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            stub_lat = $urandom_range(60, 1);
            send_block(rk, rp, aes_enc(rk, rp), 1'b1, 30);
        end
        drain();
        out_mode  = 0;
        out_force = 1'b1;
        stub_lat  = 45;

        // Timeout: the core never answers.
        stub_hang = 1'b1;
        rk = {$urandom, $urandom, $urandom, $urandom};
        send_block(rk, C1_PT, '0, 1'b0, 0);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checki("timeout_busy_cycles", n, 65);
        check1("timeout_err", err, 1'b1);
        check1("timeout_in_ready", in_ready, 1'b1);
        stub_hang = 1'b0;
        send_block(C1_KEY, C1_PT, C1_CT, 1'b1, 0);
        drain();
        check1("err_sticky", err, 1'b1);

        // Reset during collection and again during SEND.
        for (int i = 0; i < 20; i++) send_byte(8'($urandom), 0);
        do_reset();
        send_block(C1_KEY, C1_PT, C1_CT, 1'b1, 0);
        base = out_blk;
        n = 0;
        while (out_blk < base + 7 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checki("reached_send_byte7", out_blk - base, 7);
        do_reset();
        send_block(C1_KEY, C1_PT, C1_CT, 1'b1, 0);
        drain();
        check1("post_reset_err", err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_stream_loader.md
Name: aes_stream_loader

Overview:
- Byte-stream front end for aes_core, clocked on the core's system clock.
- Collects a 16-byte key followed by a 16-byte plaintext over a valid/ready byte interface and presents both as stable 128-bit buses.
- Pulses load for one cycle, waits for the core's done, captures cyphertext, then streams it out as 16 bytes over a second valid/ready interface.
- Replaces the free-running SPI path when a handshaked byte source (MCU bridge, UART) drives the core.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles to wait in WAIT for core_done before aborting. Must be greater than 45.
- TO_W, 7: timeout counter width. Must satisfy 2**TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset_n  in  1  synchronous, active-low reset.
- in_data  in  8  input byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte this cycle.
- out_data  out  8  cyphertext byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts a byte this cycle.
- key  out  128  to aes_core key.
- plaintext  out  128  to aes_core plaintext.
- load  out  1  to aes_core load.
- core_done  in  1  from aes_core done.
- cyphertext  in  128  from aes_core cyphertext.
- busy  out  1  high in LOAD and WAIT.
- err  out  1  sticky timeout flag.

Behaviour:
- Clock and reset: one clock (clk). reset_n is synchronous, active-low, sampled on posedge clk, and has priority over all other logic.
- Reset values:
  - state = COLLECT, byte counter = 0.
  - key = 0, plaintext = 0, load = 0, out_valid = 0, out_data = 0, busy = 0, err = 0.
  - in_ready = 1 in the first cycle after reset deasserts.
- Reset mid-operation: any state returns to COLLECT. Partially received bytes are discarded and an in-flight send is abandoned.
- Byte transfer: occurs on a cycle where valid and ready are both 1. Counters advance only on a transfer.
- Byte order: the first byte lands in bits [127:120], then [119:112], down to [7:0]. This matches the core's column-major packing (S0,0 first). Cyphertext goes out in the same order.
- COLLECT:
  - in_ready = 1; 5-bit counter cnt.
  - Transfers with cnt 0–15 shift into key; cnt 16–31 shift into plaintext.
  - Transfer at cnt = 31 → LOAD, cnt ← 0.
  - in_valid low stalls indefinitely with no timeout.
- LOAD:
  - load = 1 for exactly one cycle, in_ready = 0 → WAIT.
  - Timeout counter ← 0.
- WAIT:
  - load = 0.
  - key and plaintext must stay unchanged from the LOAD cycle until WAIT exits, because the core samples them over several cycles.
  - core_done is ignored in LOAD; the core clears done on the load edge.
  - If core_done = 1: capture cyphertext into the output shift register → SEND, cnt ← 0.
  - Else if the timeout counter reaches TIMEOUT_CYCLES−1: err ← 1 (sticky until reset) → COLLECT.
  - Otherwise increment the counter.
- Expected latency: with aes_core, done is seen 45 cycles after the LOAD cycle. The loader must not depend on the exact count.
- SEND:
  - out_valid = 1, out_data = shift register [127:120].
  - On transfer, shift left 8 and increment cnt. out_data and out_valid stay stable while out_ready = 0.
  - Transfer at cnt = 15 → COLLECT; in_ready rises the next cycle.
  - in_ready = 0 throughout SEND; no overlap of input and output.
- busy = (state == LOAD or WAIT).
- key and plaintext keep their values after SEND until overwritten by new input bytes.

Test Plan:
- FIPS-197 C.1 vector with real aes_core:
  - Stimulus: key bytes 00 01 … 0f, then plaintext 00 11 22 … ff, in_valid held high, out_ready high.
  - Required: load high exactly 1 cycle after the 32nd transfer; out bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a; err = 0.
- Input backpressure:
  - Stimulus: toggle in_valid randomly (~50%) during the C.1 vector.
  - Required: identical key/plaintext buses and identical cyphertext; load asserts only after 32 transfers.
- Output backpressure:
  - Stimulus: hold out_ready low for 5 cycles at bytes 0 and 15.
  - Required: out_data held at 69 and then 5a during the stalls; exactly 16 transfers; in_ready low until after the last transfer.
- Timeout:
  - Stimulus: stub core with core_done tied 0 after load.
  - Required: err rises after 64 WAIT cycles; state returns to COLLECT (in_ready = 1); err stays 1 across a subsequent good block, whose output is still correct.
- Reset mid-operation:
  - Stimulus: assert reset_n = 0 for 1 cycle after 20 input bytes, and again during SEND byte 7.
  - Required: all outputs return to reset values next cycle; a fresh 32-byte C.1 stimulus then produces the correct 16 output bytes.
- Back-to-back blocks:
  - Stimulus: two consecutive vectors (C.1, then all-zero key and plaintext) with no idle cycles.
  - Required: second output 66 e9 4b d4 ef 8a 2c 3b 88 4c fa 59 ca 34 2b 2e; key/plaintext unchanged during each WAIT.
